// File: rtl/if_layer_scheduler.sv
// Presentation sequencer for an if_layer: reset/clear, replay TIMESTEPS spike vectors,
// count output spikes per neuron, report counts and winner. Optional: IF_SCHED_TIMEOUT_EN.
module if_layer_scheduler #(
   parameter int unsigned NUM_INPUTS     = 4,
   parameter int unsigned NUM_OUTPUTS    = 1,
   parameter int unsigned TIMESTEPS      = 16,
   parameter int unsigned CNT_WIDTH      = 8,
   parameter int unsigned REST_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned WIN_W         = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_INPUTS-1:0]            in_spikes,
   output logic                             layer_rst,
   output logic [NUM_INPUTS-1:0]            layer_spike_in,
   input  logic [NUM_OUTPUTS-1:0]           layer_spike_out,
   output logic                             busy,
   output logic                             result_valid,
   output logic [NUM_OUTPUTS*CNT_WIDTH-1:0] result_counts,
   output logic [WIN_W-1:0]                 result_winner,
   output logic                             result_any,
   output logic                             result_timeout
);

   localparam int unsigned STEP_W = $clog2(TIMESTEPS + 1);
   localparam int unsigned REST_W = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   if (TIMESTEPS < 1 || REST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("if_layer_scheduler: TIMESTEPS, REST_CYCLES and TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_REPORT
   } state_e;

   state_e                                  state_q;
   logic [STEP_W-1:0]                       step_q;
   logic [REST_W-1:0]                       rest_q;
   logic [NUM_OUTPUTS-1:0][CNT_WIDTH-1:0]   cnt_q;
   logic [NUM_OUTPUTS-1:0][CNT_WIDTH-1:0]   cnt_d;
   logic                                    in_ready_q;
   logic                                    busy_q;
   logic                                    layer_rst_q;
   logic [NUM_INPUTS-1:0]                   spike_q;
   logic                                    result_valid_q;
   logic [NUM_OUTPUTS*CNT_WIDTH-1:0]        result_counts_q;
   logic [WIN_W-1:0]                        winner_q;
   logic [WIN_W-1:0]                        winner_d;
   logic                                    any_q;
   logic                                    any_d;
   logic [CNT_WIDTH-1:0]                    best_c;
   logic                                    hs_c;

`ifdef IF_SCHED_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0]                       idle_q;
   logic                                    to_hit_q;
   logic                                    result_timeout_q;
`endif

   assign hs_c = in_valid & in_ready_q;

   // Saturating per-neuron spike counters
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
         if (layer_spike_out[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   // Winner: strictly greater replaces, so ties keep the lowest index
   always_comb begin
      winner_d = '0;
      best_c   = cnt_q[0];
      for (int i = 1; i < int'(NUM_OUTPUTS); i++) begin
         if (cnt_q[i] > best_c) begin
            best_c   = cnt_q[i];
            winner_d = WIN_W'(i);
         end
      end
      any_d = |cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         step_q          <= '0;
         rest_q          <= '0;
         cnt_q           <= '0;
         in_ready_q      <= 1'b0;
         busy_q          <= 1'b0;
         layer_rst_q     <= 1'b1;
         spike_q         <= '0;
         result_valid_q  <= 1'b0;
         result_counts_q <= '0;
         winner_q        <= '0;
         any_q           <= 1'b0;
`ifdef IF_SCHED_TIMEOUT_EN
         idle_q           <= '0;
         to_hit_q         <= 1'b0;
         result_timeout_q <= 1'b0;
`endif
      end else begin
         result_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_CLEAR;
                  busy_q  <= 1'b1;
                  rest_q  <= '0;
                  step_q  <= '0;
                  cnt_q   <= '0;
`ifdef IF_SCHED_TIMEOUT_EN
                  idle_q   <= '0;
                  to_hit_q <= 1'b0;
`endif
               end
            end
            S_CLEAR: begin
               if (rest_q == REST_W'(REST_CYCLES - 1)) begin
                  state_q     <= S_RUN;
                  layer_rst_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end else begin
                  rest_q <= rest_q + REST_W'(1);
               end
            end
            S_RUN: begin
               cnt_q   <= cnt_d;
               spike_q <= hs_c ? in_spikes : '0;
               if (hs_c) begin
                  step_q <= step_q + STEP_W'(1);
`ifdef IF_SCHED_TIMEOUT_EN
                  idle_q <= '0;
`endif
                  if (step_q == STEP_W'(TIMESTEPS - 1)) begin
                     state_q    <= S_DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
`ifdef IF_SCHED_TIMEOUT_EN
               else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q    <= S_DRAIN;
                  in_ready_q <= 1'b0;
                  to_hit_q   <= 1'b1;
               end else begin
                  idle_q <= idle_q + IDLE_W'(1);
               end
`endif
            end
            // Final vector is on the layer this cycle; its response is still counted
            S_DRAIN: begin
               cnt_q       <= cnt_d;
               spike_q     <= '0;
               layer_rst_q <= 1'b1;
               state_q     <= S_REPORT;
            end
            S_REPORT: begin
               result_counts_q <= cnt_q;
               winner_q        <= winner_d;
               any_q           <= any_d;
               result_valid_q  <= 1'b1;
               busy_q          <= 1'b0;
               state_q         <= S_IDLE;
`ifdef IF_SCHED_TIMEOUT_EN
               result_timeout_q <= to_hit_q;
`endif
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready       = in_ready_q;
   assign busy           = busy_q;
   assign layer_rst      = layer_rst_q;
   assign layer_spike_in = spike_q;
   assign result_valid   = result_valid_q;
   assign result_counts  = result_counts_q;
   assign result_winner  = winner_q;
   assign result_any     = any_q;
`ifdef IF_SCHED_TIMEOUT_EN
   assign result_timeout = result_timeout_q;
`else
   assign result_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_if_layer_scheduler.sv
// Self-checking bench for if_layer_scheduler with a behavioural layer model (neuron i echoes
// spike_in[i], optionally forced high) and a presentation-level reference model.
module tb_if_layer_scheduler;

   localparam int unsigned NI   = 4;
   localparam int unsigned NO   = 3;
   localparam int unsigned TS   = 6;
   localparam int unsigned CW   = 3;
   localparam int unsigned REST = 2;
   localparam int unsigned TMO  = 8;
   localparam int unsigned WW   = 2;
   localparam int          SAT  = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [NI-1:0]     in_spikes;
   logic              layer_rst;
   logic [NI-1:0]     layer_spike_in;
   logic [NO-1:0]     layer_spike_out;
   logic              busy;
   logic              result_valid;
   logic [NO*CW-1:0]  result_counts;
   logic [WW-1:0]     result_winner;
   logic              result_any;
   logic              result_timeout;

   logic [NO-1:0]     force_nrn;
   logic [NI-1:0]     vec [TS];
   int                gap [TS];
   int                checks;
   int                errors;
   int                cyc;

   always #5 clk = ~clk;

   assign layer_spike_out = layer_rst ? '0 : (layer_spike_in[NO-1:0] | force_nrn);

   if_layer_scheduler #(
      .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .TIMESTEPS(TS), .CNT_WIDTH(CW),
      .REST_CYCLES(REST), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_spikes(in_spikes), .layer_rst(layer_rst), .layer_spike_in(layer_spike_in),
      .layer_spike_out(layer_spike_out), .busy(busy), .result_valid(result_valid),
      .result_counts(result_counts), .result_winner(result_winner), .result_any(result_any),
      .result_timeout(result_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Expected results: a neuron's count is the number of cycles its output was high while the
   // layer was out of reset (one cycle per replayed vector, or every RUN+DRAIN cycle if forced).
   task automatic expect_results(input int window, input int nvec, output logic [NO*CW-1:0] ecat,
                                 output int ew, output int eany);
      int n [NO];
      int mx;
      mx = 0;
      for (int i = 0; i < int'(NO); i++) begin
         n[i] = 0;
         if (force_nrn[i]) n[i] = window;
         else for (int k = 0; k < nvec; k++) if (vec[k][i]) n[i]++;
         if (n[i] > SAT) n[i] = SAT;
         if (n[i] > mx) mx = n[i];
         ecat[i*CW +: CW] = CW'(n[i]);
      end
      ew = 0;
      for (int i = int'(NO) - 1; i >= 0; i--) if (n[i] == mx) ew = i;
      eany = (mx > 0) ? 1 : 0;
   endtask

   task automatic present(input int abort_at);
      int sumg;
      int ew;
      int eany;
      logic [NO*CW-1:0] ecat;
      sumg = 0;
      for (int k = 0; k < int'(TS); k++) sumg += gap[k];
      cyc       = 0;
      start     = 1'b1;
      in_valid  = 1'b1;
      in_spikes = 4'($urandom);
      tick();
      start = 1'b0;
      chk("clear_busy", 32'(busy), 1);
      chk("clear_layer_rst", 32'(layer_rst), 1);
      chk("clear_ready", 32'(in_ready), 0);
      repeat (REST - 1) tick();
      chk("clear_ready_last", 32'(in_ready), 0);
      tick();
      in_valid = 1'b0;
      chk("first_ready", 32'(in_ready), 1);
      chk("run_layer_rst", 32'(layer_rst), 0);
      chk("clear_no_accept", 32'(layer_spike_in), 0);
      for (int k = 0; k < int'(TS); k++) begin
         if (k == abort_at) begin
            in_valid = 1'b0;
            rst = 1'b0;
            #1;
            chk("abort_layer_rst", 32'(layer_rst), 1);
            chk("abort_ready", 32'(in_ready), 0);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_counts", 32'(result_counts), 0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            tick();
            return;
         end
         for (int g = 0; g < gap[k]; g++) begin
            in_valid  = 1'b0;
            in_spikes = 4'($urandom);
            start     = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            chk("gap_zero", 32'(layer_spike_in), 0);
            chk("run_busy", 32'(busy), 1);
            chk("run_ready", 32'(in_ready), 1);
         end
         in_valid  = 1'b1;
         in_spikes = vec[k];
         chk("hs_ready", 32'(in_ready), 1);
         tick();
         chk("replay", 32'(layer_spike_in), 32'(vec[k]));
      end
      in_valid = 1'b0;
      chk("drain_ready", 32'(in_ready), 0);
      chk("drain_busy", 32'(busy), 1);
      tick();
      chk("report_spike_zero", 32'(layer_spike_in), 0);
      chk("report_no_valid", 32'(result_valid), 0);
      tick();
      expect_results(int'(TS) + sumg + 1, int'(TS), ecat, ew, eany);
      chk("result_valid", 32'(result_valid), 1);
      chk("latency", 32'(cyc), 32'(int'(REST + TS) + sumg + 3));
      chk("idle_busy", 32'(busy), 0);
      chk("counts", 32'(result_counts), 32'(ecat));
      chk("winner", 32'(result_winner), 32'(ew));
      chk("any", 32'(result_any), 32'(eany));
      chk("timeout_flag", 32'(result_timeout), 0);
      tick();
      chk("valid_pulse", 32'(result_valid), 0);
      chk("counts_hold", 32'(result_counts), 32'(ecat));
   endtask

   task automatic randomize_stim(input int max_gap);
      for (int k = 0; k < int'(TS); k++) begin
         vec[k] = 4'($urandom);
         gap[k] = $urandom_range(0, max_gap);
      end
   endtask

   initial begin
      int n;
      int ew;
      int eany;
      logic [NO*CW-1:0] ecat;
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_spikes = '0;
      force_nrn = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_layer_rst", 32'(layer_rst), 1);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(result_valid), 0);
      chk("rst_counts", 32'(result_counts), 0);
      chk("rst_winner", 32'(result_winner), 0);
      chk("rst_any", 32'(result_any), 0);
      chk("rst_timeout", 32'(result_timeout), 0);
      chk("rst_spike_in", 32'(layer_spike_in), 0);
      rst = 1'b1;
      in_valid  = 1'b1;
      in_spikes = 4'hF;
      tick();
      tick();
      chk("idle_no_accept", 32'(layer_spike_in), 0);
      chk("idle_not_busy", 32'(busy), 0);
      in_valid = 1'b0;

      // Tie between neurons 1 and 2 resolves to the lower index
      vec[0] = 4'b0110; vec[1] = 4'b0110; vec[2] = 4'b0110;
      vec[3] = 4'b0001; vec[4] = 4'b0000; vec[5] = 4'b1000;
      for (int k = 0; k < int'(TS); k++) gap[k] = 0;
      present(-1);

      // Reset in the middle of RUN, then a clean presentation
      randomize_stim(2);
      present(5);
      present(-1);

      // Forced neuron saturates its counter
      force_nrn = 3'b001;
      randomize_stim(3);
      present(-1);
      force_nrn = '0;

      for (int r = 0; r < 4; r++) begin
         randomize_stim(3);
         present(-1);
      end

`ifdef IF_SCHED_TIMEOUT_EN
      randomize_stim(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!in_ready && n < 10) begin tick(); n++; end
      chk("to_ready_wait", 32'(n < 10), 1);
      in_valid = 1'b1; in_spikes = vec[0]; tick();
      in_spikes = vec[1]; tick();
      in_valid = 1'b0;
      n = 0;
      while (!result_valid && n < 40) begin tick(); n++; end
      expect_results(0, 2, ecat, ew, eany);
      chk("to_report_wait", 32'(n < 40), 1);
      chk("to_flag", 32'(result_timeout), 1);
      chk("to_counts", 32'(result_counts), 32'(ecat));
      chk("to_winner", 32'(result_winner), 32'(ew));
`else
      // Long stall: RUN keeps waiting with in_ready high
      randomize_stim(1);
      gap[2] = 100;
      present(-1);
      n = 0; ew = 0; eany = 0; ecat = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_layer_scheduler.md
Name: if_layer_scheduler

Overview:
Sequences one inference "presentation" through an if_layer instance. Holds the layer in reset between presentations, accepts TIMESTEPS input spike vectors over a valid/ready stream and replays each to the layer for one cycle, then counts output spikes per neuron. At the end it reports the per-neuron counts and the winning neuron, for the classifier logic above the layer.

Parameters:
NUM_INPUTS, 4, width of input spike vector (matches layer).
NUM_OUTPUTS, 1, number of layer output neurons.
TIMESTEPS, 16, spike vectors per presentation (>=1).
CNT_WIDTH, 8, per-neuron spike counter width.
REST_CYCLES, 2, cycles layer_rst held in CLEAR (>=1).
TIMEOUT_CYCLES, 256, stall limit; used only with IF_SCHED_TIMEOUT_EN.
WIN_W, max(1,$clog2(NUM_OUTPUTS)), winner index width (derived localparam).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  begin presentation; sampled only in IDLE.
in_valid  input  1  input spike vector valid.
in_ready  output  1  scheduler accepts vector.
in_spikes  input  NUM_INPUTS  spike vector for one timestep.
layer_rst  output  1  active-high reset to if_layer.
layer_spike_in  output  NUM_INPUTS  registered drive to if_layer spike_in.
layer_spike_out  input  NUM_OUTPUTS  if_layer spike_out.
busy  output  1  high in any state except IDLE.
result_valid  output  1  one-cycle pulse, results updated.
result_counts  output  NUM_OUTPUTS*CNT_WIDTH  neuron i count at [i*CNT_WIDTH +: CNT_WIDTH].
result_winner  output  WIN_W  index of highest count.
result_any  output  1  at least one output spike seen.
result_timeout  output  1  presentation aborted by timeout.

Behaviour:
- Reset (rst=0, async): state IDLE. layer_rst=1. in_ready, busy, result_valid, result_any and result_timeout are 0. layer_spike_in, result_counts and result_winner are 0. Step, rest and timeout counters are 0. Reset mid-presentation discards all progress.
- IDLE: layer_rst=1, in_ready=0, layer_spike_in=0. start=1 moves to CLEAR next cycle. start in any other state is ignored.
- CLEAR: layer_rst=1 for exactly REST_CYCLES cycles. Counters and step counter are zeroed on entry. Then RUN.
- RUN: layer_rst=0 and in_ready=1.
  - On a handshake (in_valid&in_ready), in_spikes is registered onto layer_spike_in for exactly the next cycle. Otherwise layer_spike_in=0; gap cycles are not timesteps.
  - The step counter increments per handshake. At the TIMESTEPS-th handshake, in_ready drops the following cycle and the state moves to DRAIN.
- DRAIN: exactly 1 cycle. Lets the final vector reach the layer and its response be counted. in_ready=0, layer_spike_in=0 after the last vector's cycle.
- Counting: in RUN and DRAIN, every cycle with layer_spike_out[i]=1 increments count i. Counts saturate at 2^CNT_WIDTH-1 (no wrap).
- REPORT: 1 cycle.
  - result_counts, result_any and result_winner are latched.
  - Winner = highest count; ties go to the lowest index. All-zero counts give winner=0, result_any=0.
  - result_valid=1 for this cycle only. Results hold until the next REPORT or reset.
  - Next state IDLE.
- Latency: start to first in_ready = REST_CYCLES+1 cycles. With in_valid held high, start to result_valid = REST_CYCLES+TIMESTEPS+3 cycles.
- in_valid in IDLE, CLEAR, DRAIN or REPORT: not accepted, no effect.

Optional Feature:
Macro IF_SCHED_TIMEOUT_EN.
- Defined: in RUN, a counter tracks consecutive cycles with no handshake. When it reaches TIMEOUT_CYCLES, the state goes directly to DRAIN, then REPORT with result_timeout=1. Partial counts are reported. The counter clears on each handshake.
- Undefined: no timeout logic; RUN waits indefinitely; result_timeout tied 0.

Test Plan:
- Reset mid-RUN: rst low at step 5 -> same cycle layer_rst=1, in_ready=0, busy=0, result_counts=0; next start performs a full clean presentation.
- NUM_OUTPUTS=1, TIMESTEPS=4, REST_CYCLES=2, in_valid constant, model layer echoing in_spikes[0] -> result_valid 9 cycles after start, count matches number of vectors with bit0=1, winner=0.
- NUM_OUTPUTS=3, inject spikes on neurons 1 and 2 three times each, neuron 0 once -> counts {1,3,3}, winner=1 (tie to lowest).
- CNT_WIDTH=2, neuron 0 spikes every cycle for 16 steps -> count 3 (saturated), result_any=1.
- in_valid toggling with random gaps -> exactly TIMESTEPS vectors replayed, each on layer_spike_in for one cycle, zeros during gaps; start pulsed during RUN ignored.
- IF_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8: stop in_valid after step 2 -> REPORT with result_timeout=1 and partial counts; without macro, still busy after 100 idle cycles.
